// File: rtl/parity_sweep_checker_pkg.sv
// -----------------------------------------------------------------------------
// parity_sweep_pkg
//
// Shared definitions for the parity sweep checker:
//   - sweep_state_t : FSM state encoding (IDLE / DRIVE / DONE)
//   - MODE_XOR / MODE_XNOR : selects the expected parity function
//   - MAX_WIDTH : widest vector the checker supports
//   - parity_ref() : reference parity of a vector for a given mode
// -----------------------------------------------------------------------------
package parity_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

    localparam int MODE_XOR  = 0;
    localparam int MODE_XNOR = 1;

    localparam int MAX_WIDTH = 16;

    // Narrower vectors are zero-extended by the caller; the extra zero bits
    // do not change the XOR reduction, so one function covers every width.
    function automatic logic parity_ref(input logic [MAX_WIDTH-1:0] vec,
                                        input logic                 xnor_mode);
        parity_ref = (^vec) ^ xnor_mode;
    endfunction

endpackage

// File: rtl/parity_sweep_checker.sv
// -----------------------------------------------------------------------------
// parity_sweep_checker
//
// Exhaustive stimulus engine for an N-input parity circuit. Sweeps vec_out
// through every value 0 .. 2^WIDTH-1, holding each for HOLD cycles, samples
// the circuit's response on the last hold cycle and compares it with the
// expected XOR (MODE=0) or XNOR (MODE=1) of the vector. Mismatches are
// counted and the first failing vector is captured.
//
// Parameters:
//   WIDTH : number of inputs of the circuit under test (1..16)
//   HOLD  : cycles each vector is held (>= 1)
//   MODE  : 0 = expect XOR of all inputs, 1 = expect XNOR
//
// Ports:
//   clk             in   system clock, rising edge
//   rst             in   synchronous active-high reset
//   start           in   begins a sweep when idle or done
//   vec_out         out  [WIDTH-1:0] vector driven to the circuit
//   dut_in          in   circuit output
//   busy            out  high while sweeping
//   done            out  high from sweep completion until next start/reset
//   pass            out  done with zero mismatches
//   err_count       out  [WIDTH:0] mismatching vectors in current/last sweep
//   first_err_vec   out  [WIDTH-1:0] vector of the first mismatch
//   first_err_valid out  first_err_vec holds a captured value
// -----------------------------------------------------------------------------
module parity_sweep_checker
    import parity_sweep_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int HOLD  = 4,
    parameter int MODE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] vec_out,
    input  logic             dut_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_count,
    output logic [WIDTH-1:0] first_err_vec,
    output logic             first_err_valid
);

    localparam int                HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [WIDTH-1:0]  VEC_LAST  = '1;
    localparam logic              XNOR_MODE = (MODE == MODE_XNOR);

    sweep_state_t      state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              expected;
    logic              mismatch;

    // Expected response of a correct circuit to the vector currently driven.
    always_comb begin
        expected = parity_ref(MAX_WIDTH'(vec_out), XNOR_MODE);
        mismatch = (dut_in != expected);
    end

    // Pass is derived combinationally so it always agrees with the frozen
    // error count once the sweep has completed.
    assign pass = done && (err_count == '0);

    // Sweep controller: the hold timer and the vector counter live in the
    // same block as the FSM. A start in IDLE or DONE clears all results and
    // launches a fresh sweep from vector 0; start during DRIVE is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            vec_out         <= '0;
            hold_cnt        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= DRIVE;
                        vec_out         <= '0;
                        hold_cnt        <= '0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        err_count       <= '0;
                        first_err_vec   <= '0;
                        first_err_valid <= 1'b0;
                    end else if (state == IDLE) begin
                        vec_out <= '0;
                    end
                end

                DRIVE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        // Last hold cycle: the circuit output has settled.
                        if (mismatch) begin
                            err_count <= err_count + (WIDTH+1)'(1);
                            if (!first_err_valid) begin
                                first_err_vec   <= vec_out;
                                first_err_valid <= 1'b1;
                            end
                        end
                        // Stop at all ones so vec_out never wraps.
                        if (vec_out == VEC_LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            vec_out  <= vec_out + WIDTH'(1);
                            hold_cnt <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_sweep_checker.sv
// -----------------------------------------------------------------------------
// tb_parity_sweep_checker
//
// Two checker instances: A (WIDTH=4, HOLD=4, MODE=XOR) and B (WIDTH=2,
// HOLD=1, MODE=XNOR). Each drives a behavioural circuit model selectable as
// correct XOR, stuck-at-0, XNOR, or XOR with a random per-vector fault table.
// Expected sweep results come from a reference walk over every vector using
// plain arithmetic.
// -----------------------------------------------------------------------------
module tb_parity_sweep_checker;

    localparam int WIDTH_A = 4;
    localparam int HOLD_A  = 4;
    localparam int MODE_A  = 0;
    localparam int LAT_A   = (1 << WIDTH_A) * HOLD_A;

    localparam int WIDTH_B = 2;
    localparam int HOLD_B  = 1;
    localparam int MODE_B  = 1;
    localparam int LAT_B   = (1 << WIDTH_B) * HOLD_B;

    localparam int KIND_XOR    = 0;
    localparam int KIND_STUCK0 = 1;
    localparam int KIND_XNOR   = 2;
    localparam int KIND_RANDOM = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    logic [WIDTH_A-1:0] vec_a;
    logic               dut_in_a;
    logic               busy_a, done_a, pass_a, first_valid_a;
    logic [WIDTH_A:0]   err_a;
    logic [WIDTH_A-1:0] first_vec_a;

    logic [WIDTH_B-1:0] vec_b;
    logic               dut_in_b;
    logic               busy_b, done_b, pass_b, first_valid_b;
    logic [WIDTH_B:0]   err_b;
    logic [WIDTH_B-1:0] first_vec_b;

    int          kind_a = KIND_XOR;
    int          kind_b = KIND_XNOR;
    logic [15:0] fault_tbl = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    parity_sweep_checker #(.WIDTH(WIDTH_A), .HOLD(HOLD_A), .MODE(MODE_A)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .vec_out(vec_a), .dut_in(dut_in_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_err_vec(first_vec_a), .first_err_valid(first_valid_a)
    );

    parity_sweep_checker #(.WIDTH(WIDTH_B), .HOLD(HOLD_B), .MODE(MODE_B)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .vec_out(vec_b), .dut_in(dut_in_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_err_vec(first_vec_b), .first_err_valid(first_valid_b)
    );

    // Behavioural circuit under test, chosen by kind.
    function automatic logic circuit_resp(input int kind, input int v, input logic [15:0] tbl);
        int odd;
        odd = $countones(v) % 2;
        case (kind)
            KIND_XOR:    circuit_resp = (odd == 1);
            KIND_STUCK0: circuit_resp = 1'b0;
            KIND_XNOR:   circuit_resp = (odd == 0);
            default:     circuit_resp = (odd == 1) ^ tbl[v];
        endcase
    endfunction

    always_comb dut_in_a = circuit_resp(kind_a, int'(vec_a), fault_tbl);
    always_comb dut_in_b = circuit_resp(kind_b, int'(vec_b), fault_tbl);

    // Reference: walk every vector, compare circuit answer with the parity
    // the checker should expect, count disagreements and note the first.
    task automatic model_sweep(input int width, input int mode, input int kind,
                               output int errs, output int first, output bit valid);
        errs  = 0;
        first = 0;
        valid = 0;
        for (int v = 0; v < (1 << width); v++) begin
            bit want;
            want = (($countones(v) % 2) ^ mode) != 0;
            if (circuit_resp(kind, v, fault_tbl) != want) begin
                errs++;
                if (!valid) begin
                    first = v;
                    valid = 1;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Set inputs at a falling edge and move to the next falling edge, so
    // exactly one rising edge has sampled them.
    task automatic applyStimulus(input logic r, input logic sa, input logic sb);
        rst     = r;
        start_a = sa;
        start_b = sb;
        @(negedge clk);
    endtask

    task automatic check_reset_a(input string tag);
        checkOutput({tag, "_vec"},   vec_a, 0);
        checkOutput({tag, "_busy"},  busy_a, 0);
        checkOutput({tag, "_done"},  done_a, 0);
        checkOutput({tag, "_pass"},  pass_a, 0);
        checkOutput({tag, "_err"},   err_a, 0);
        checkOutput({tag, "_fvec"},  first_vec_a, 0);
        checkOutput({tag, "_fval"},  first_valid_a, 0);
    endtask

    // Full sweep on instance A; start stays high for hold_len cycles after
    // the launching edge (0 = single-cycle pulse).
    task automatic run_sweep_a(input int kind, input int hold_len);
        int errs, first;
        bit valid;
        kind_a = kind;
        model_sweep(WIDTH_A, MODE_A, kind, errs, first, valid);
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int j = 0; j <= LAT_A; j++) begin
            if (j >= hold_len) start_a = 1'b0;
            if (j == 0) begin
                checkOutput("a_start_err", err_a, 0);
                checkOutput("a_start_fval", first_valid_a, 0);
            end
            if (j < LAT_A) begin
                checkOutput("a_vec", vec_a, j / HOLD_A);
                checkOutput("a_busy", busy_a, 1);
                checkOutput("a_done", done_a, 0);
                @(negedge clk);
            end else begin
                checkOutput("a_end_done", done_a, 1);
                checkOutput("a_end_busy", busy_a, 0);
                checkOutput("a_end_vec", vec_a, 4'hF);
                checkOutput("a_err", err_a, errs);
                checkOutput("a_fval", first_valid_a, valid);
                if (valid) checkOutput("a_fvec", first_vec_a, first);
                checkOutput("a_pass", pass_a, errs == 0);
            end
        end
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("a_frozen_done", done_a, 1);
        checkOutput("a_frozen_err", err_a, errs);
        checkOutput("a_frozen_vec", vec_a, 4'hF);
    endtask

    task automatic run_sweep_b(input int kind);
        int errs, first;
        bit valid;
        kind_b = kind;
        model_sweep(WIDTH_B, MODE_B, kind, errs, first, valid);
        applyStimulus(1'b0, 1'b0, 1'b1);
        start_b = 1'b0;
        for (int j = 0; j <= LAT_B; j++) begin
            if (j < LAT_B) begin
                checkOutput("b_vec", vec_b, j);
                checkOutput("b_busy", busy_b, 1);
                @(negedge clk);
            end else begin
                checkOutput("b_done", done_b, 1);
                checkOutput("b_vec_end", vec_b, 3);
                checkOutput("b_err", err_b, errs);
                checkOutput("b_fval", first_valid_b, valid);
                if (valid) checkOutput("b_fvec", first_vec_b, first);
                checkOutput("b_pass", pass_b, errs == 0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(negedge clk);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        check_reset_a("rst");
        checkOutput("rst_b_busy", busy_b, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        check_reset_a("idle");

        run_sweep_a(KIND_XOR, 0);
        run_sweep_a(KIND_STUCK0, 0);
        run_sweep_a(KIND_XNOR, 0);
        // restart from DONE after a failing sweep, start held into DRIVE
        run_sweep_a(KIND_XOR, 1 + int'($urandom_range(40)));

        for (int i = 0; i < 3; i++) begin
            fault_tbl = 16'($urandom);
            run_sweep_a(KIND_RANDOM, int'($urandom_range(LAT_A - 1)));
        end

        // reset in the middle of vector 5 (hold_cnt = 2)
        kind_a = KIND_XOR;
        applyStimulus(1'b0, 1'b1, 1'b0);
        start_a = 1'b0;
        repeat (5 * HOLD_A + 2) @(negedge clk);
        checkOutput("mid_vec", vec_a, 5);
        applyStimulus(1'b1, 1'b0, 1'b0);
        check_reset_a("midrst");
        // reset and start together: reset wins, nothing launches
        applyStimulus(1'b1, 1'b1, 1'b0);
        check_reset_a("collide");
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("collide_idle_busy", busy_a, 0);
        run_sweep_a(KIND_XOR, 0);

        run_sweep_b(KIND_XNOR);
        run_sweep_b(KIND_XOR);
        fault_tbl = 16'($urandom);
        run_sweep_b(KIND_RANDOM);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
